// File: rtl/rob_mc.sv
// Reorder buffer: allocates tags in program order, absorbs multi-port completions,
// retires up to COMMIT_W ready entries per cycle and flushes younger work on a mispredict.
module rob_mc #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TAG_W     = $clog2(DEPTH),
    parameter int unsigned CDB_PORTS = 3,
    parameter int unsigned COMMIT_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_valid,
    input  logic [31:0]                   alloc_pc,
    input  logic [4:0]                    alloc_rd,
    output logic                          alloc_ready,
    output logic [TAG_W-1:0]              alloc_tag,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
    input  logic [CDB_PORTS-1:0]          cdb_mispredict,
    input  logic [CDB_PORTS*32-1:0]       cdb_target,
    output logic [COMMIT_W-1:0]           commit_valid,
    output logic [COMMIT_W*TAG_W-1:0]     commit_tag,
    output logic [COMMIT_W*5-1:0]         commit_rd,
    output logic [COMMIT_W*DATA_W-1:0]    commit_data,
    output logic [COMMIT_W*32-1:0]        commit_pc,
    output logic                          flush,
    output logic [31:0]                   flush_pc,
    output logic [TAG_W:0]                count,
    output logic                          empty
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d, ready_q, ready_d, mis_q, mis_d;
    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       pc_d   [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [4:0]        rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [31:0]       tgt_q  [DEPTH];
    logic [31:0]       tgt_d  [DEPTH];

    logic              alloc_fire;
    logic [CNT_W-1:0]  n_ret;
    logic              go;
    logic [TAG_W-1:0]  cidx, ctag, ridx;

    assign alloc_ready = (count_q < CNT_W'(DEPTH)) && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);

    // In-order retire window; a mispredicted entry closes the group
    always_comb begin
        commit_valid = '0;
        commit_tag   = '0;
        commit_rd    = '0;
        commit_data  = '0;
        commit_pc    = '0;
        flush        = 1'b0;
        flush_pc     = '0;
        n_ret        = '0;
        go           = 1'b1;
        cidx         = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            cidx = head_q + TAG_W'(i);
            if (go && valid_q[cidx] && ready_q[cidx]) begin
                commit_valid[i]                   = 1'b1;
                commit_tag[i*TAG_W +: TAG_W]      = cidx;
                commit_rd[i*5 +: 5]               = rd_q[cidx];
                commit_data[i*DATA_W +: DATA_W]   = data_q[cidx];
                commit_pc[i*32 +: 32]             = pc_q[cidx];
                n_ret                             = n_ret + CNT_W'(1);
                if (mis_q[cidx]) begin
                    flush    = 1'b1;
                    flush_pc = tgt_q[cidx];
                    go       = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

    // Next state: completions, then retirement, then allocation, flush overrides all
    always_comb begin
        head_d  = head_q + TAG_W'(n_ret);
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(alloc_fire) - n_ret;
        valid_d = valid_q;
        ready_d = ready_q;
        mis_d   = mis_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        ctag    = '0;
        ridx    = '0;

        // Ascending port order lets the highest port win a shared tag
        for (int p = 0; p < CDB_PORTS; p++) begin
            ctag = cdb_tag[p*TAG_W +: TAG_W];
            if (cdb_valid[p] && valid_q[ctag]) begin
                ready_d[ctag] = 1'b1;
                mis_d[ctag]   = cdb_mispredict[p];
                data_d[ctag]  = cdb_data[p*DATA_W +: DATA_W];
                tgt_d[ctag]   = cdb_target[p*32 +: 32];
            end
        end

        for (int i = 0; i < COMMIT_W; i++) begin
            ridx = head_q + TAG_W'(i);
            if (commit_valid[i]) begin
                valid_d[ridx] = 1'b0;
                ready_d[ridx] = 1'b0;
                mis_d[ridx]   = 1'b0;
            end
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            mis_d[tail_q]   = 1'b0;
            pc_d[tail_q]    = alloc_pc;
            rd_d[tail_q]    = alloc_rd;
            tail_d          = tail_q + TAG_W'(1);
        end

        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            mis_d   = '0;
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
            mis_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            mis_q   <= mis_d;
        end
    end

    // Payload is qualified by valid/ready, so it needs no reset
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        rd_q   <= rd_d;
        data_q <= data_d;
        tgt_q  <= tgt_d;
    end

endmodule

// File: tb/tb_rob_mc.sv
// Directed per-cycle vector bench for rob_mc: each record drives one cycle of inputs
// and lists the outputs expected before the following clock edge.
module tb_rob_mc;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned CDB_PORTS = 3;
    localparam int unsigned COMMIT_W  = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        alloc_valid;
    logic [31:0]                 alloc_pc;
    logic [4:0]                  alloc_rd;
    logic                        alloc_ready;
    logic [TAG_W-1:0]            alloc_tag;
    logic [CDB_PORTS-1:0]        cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_data;
    logic [CDB_PORTS-1:0]        cdb_mispredict;
    logic [CDB_PORTS*32-1:0]     cdb_target;
    logic [COMMIT_W-1:0]         commit_valid;
    logic [COMMIT_W*TAG_W-1:0]   commit_tag;
    logic [COMMIT_W*5-1:0]       commit_rd;
    logic [COMMIT_W*DATA_W-1:0]  commit_data;
    logic [COMMIT_W*32-1:0]      commit_pc;
    logic                        flush;
    logic [31:0]                 flush_pc;
    logic [TAG_W:0]              count;
    logic                        empty;

    rob_mc #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W),
        .CDB_PORTS(CDB_PORTS), .COMMIT_W(COMMIT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_pc(commit_pc),
        .flush(flush), .flush_pc(flush_pc), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        chk;
        logic        av;
        logic [2:0]  cv;
        logic [3:0]  t0, t1, t2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  mp;
        logic [31:0] tgt;
        logic        ear;
        logic [3:0]  eat;
        logic [1:0]  ecv;
        logic [3:0]  ect0, ect1;
        logic [31:0] ecd0, ecd1;
        logic        efl;
        logic [31:0] efpc;
        logic [4:0]  ecnt;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;

    // Default completion data is 0xD000_0000 + tag; alloc pc/rd derive from the tag too
    function automatic vec_t mk(input int unsigned av, input int unsigned cv,
                                input int unsigned t0, input int unsigned t1, input int unsigned t2,
                                input int unsigned mp, input int unsigned tgt,
                                input int unsigned ear, input int unsigned eat,
                                input int unsigned ecv, input int unsigned ect0, input int unsigned ect1,
                                input int unsigned efl, input int unsigned efpc, input int unsigned ecnt);
        vec_t v;
        v.rst  = 1'b0;
        v.chk  = 1'b1;
        v.av   = 1'(av);
        v.cv   = 3'(cv);
        v.t0   = 4'(t0);
        v.t1   = 4'(t1);
        v.t2   = 4'(t2);
        v.d0   = 32'hD000_0000 + 32'(t0);
        v.d1   = 32'hD000_0000 + 32'(t1);
        v.d2   = 32'hD000_0000 + 32'(t2);
        v.mp   = 3'(mp);
        v.tgt  = 32'(tgt);
        v.ear  = 1'(ear);
        v.eat  = 4'(eat);
        v.ecv  = 2'(ecv);
        v.ect0 = 4'(ect0);
        v.ect1 = 4'(ect1);
        v.ecd0 = 32'hD000_0000 + 32'(ect0);
        v.ecd1 = 32'hD000_0000 + 32'(ect1);
        v.efl  = 1'(efl);
        v.efpc = 32'(efpc);
        v.ecnt = 5'(ecnt);
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v.rst = 1'b1;
        v.chk = 1'b0;
        return v;
    endfunction

    function automatic vec_t al(input int unsigned tag, input int unsigned cnt);
        return mk(1, 0, 0, 0, 0, 0, 0, 1, tag, 0, 0, 0, 0, 0, cnt);
    endfunction

    function automatic vec_t idle(input int unsigned ear, input int unsigned eat,
                                  input int unsigned ecv, input int unsigned ect0,
                                  input int unsigned ect1, input int unsigned ecnt);
        return mk(0, 0, 0, 0, 0, 0, 0, ear, eat, ecv, ect0, ect1, 0, 0, ecnt);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0h exp %0h", nm, vidx, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        rst            = v.rst;
        alloc_valid    = v.av;
        alloc_pc       = 32'h1000 + {26'd0, v.eat, 2'b00};
        alloc_rd       = {1'b0, v.eat} + 5'd1;
        cdb_valid      = v.cv;
        cdb_tag        = {v.t2, v.t1, v.t0};
        cdb_data       = {v.d2, v.d1, v.d0};
        cdb_mispredict = v.mp;
        cdb_target     = {3{v.tgt}};
        @(negedge clk);
        if (v.chk) begin
            check("alloc_ready",  32'(alloc_ready),  32'(v.ear));
            check("alloc_tag",    32'(alloc_tag),    32'(v.eat));
            check("commit_valid", 32'(commit_valid), 32'(v.ecv));
            check("flush",        32'(flush),        32'(v.efl));
            check("count",        32'(count),        32'(v.ecnt));
            check("empty",        32'(empty),        32'(v.ecnt == 5'd0));
            if (v.ecv[0]) begin
                check("commit_tag0",  32'(commit_tag[3:0]), 32'(v.ect0));
                check("commit_data0", commit_data[31:0],    v.ecd0);
                check("commit_pc0",   commit_pc[31:0],      32'h1000 + {26'd0, v.ect0, 2'b00});
                check("commit_rd0",   32'(commit_rd[4:0]),  32'({1'b0, v.ect0} + 5'd1));
            end
            if (v.ecv[1]) begin
                check("commit_tag1",  32'(commit_tag[7:4]), 32'(v.ect1));
                check("commit_data1", commit_data[63:32],   v.ecd1);
            end
            if (v.efl) check("flush_pc", flush_pc, v.efpc);
        end
        @(posedge clk);
        #1;
        vidx++;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout vec %0d", vidx);
        $fatal(1);
    end

    initial begin
        vec_t v;

        // Fill to capacity, 17th request refused
        vq.push_back(mk_rst());
        for (int i = 0; i < 16; i++) vq.push_back(al(i, i));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16));
        // Out-of-order completion: 1 then 0, both retire together
        vq.push_back(mk(0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16));
        vq.push_back(mk(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16));
        vq.push_back(idle(0, 0, 2'b11, 0, 1, 16));
        vq.push_back(idle(1, 0, 0, 0, 0, 14));

        // Hole at tag 1 holds tag 2
        vq.push_back(mk_rst());
        for (int i = 0; i < 3; i++) vq.push_back(al(i, i));
        vq.push_back(mk(0, 3'b101, 0, 0, 2, 0, 0, 1, 3, 0, 0, 0, 0, 0, 3));
        vq.push_back(idle(1, 3, 2'b01, 0, 0, 3));
        vq.push_back(idle(1, 3, 0, 0, 0, 2));
        vq.push_back(mk(0, 3'b010, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 2));
        vq.push_back(idle(1, 3, 2'b11, 1, 2, 2));
        vq.push_back(idle(1, 3, 0, 0, 0, 0));

        // Mispredict on tag 3 flushes 4..7; alloc during flush refused
        vq.push_back(mk_rst());
        for (int i = 0; i < 8; i++) vq.push_back(al(i, i));
        vq.push_back(mk(0, 3'b111, 0, 1, 2, 0, 0, 1, 8, 0, 0, 0, 0, 0, 8));
        vq.push_back(mk(0, 3'b001, 3, 0, 0, 3'b001, 32'h400, 1, 8, 2'b11, 0, 1, 0, 0, 8));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8, 2'b11, 2, 3, 1, 32'h400, 6));
        vq.push_back(idle(1, 4, 0, 0, 0, 0));
        vq.push_back(al(4, 0));
        vq.push_back(idle(1, 5, 0, 0, 0, 1));

        // Wrap: refill 0,1 after retiring them, then retire across 15 -> 0
        vq.push_back(mk_rst());
        for (int i = 0; i < 16; i++) vq.push_back(al(i, i));
        vq.push_back(mk(0, 3'b011, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16));
        vq.push_back(idle(0, 0, 2'b11, 0, 1, 16));
        vq.push_back(al(0, 14));
        vq.push_back(al(1, 15));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 16));
        vq.push_back(mk(0, 3'b001,  2,  0, 0, 0, 0, 0, 2, 0,     0,  0, 0, 0, 16));
        vq.push_back(mk(0, 3'b011,  3,  4, 0, 0, 0, 0, 2, 2'b01, 2,  0, 0, 0, 16));
        vq.push_back(mk(0, 3'b011,  5,  6, 0, 0, 0, 1, 2, 2'b11, 3,  4, 0, 0, 15));
        vq.push_back(mk(0, 3'b011,  7,  8, 0, 0, 0, 1, 2, 2'b11, 5,  6, 0, 0, 13));
        vq.push_back(mk(0, 3'b011,  9, 10, 0, 0, 0, 1, 2, 2'b11, 7,  8, 0, 0, 11));
        vq.push_back(mk(0, 3'b011, 11, 12, 0, 0, 0, 1, 2, 2'b11, 9, 10, 0, 0, 9));
        vq.push_back(mk(0, 3'b011, 13, 14, 0, 0, 0, 1, 2, 2'b11, 11, 12, 0, 0, 7));
        vq.push_back(mk(0, 3'b011, 15,  0, 0, 0, 0, 1, 2, 2'b11, 13, 14, 0, 0, 5));
        vq.push_back(mk(0, 3'b100,  0,  0, 1, 0, 0, 1, 2, 2'b11, 15,  0, 0, 0, 3));
        vq.push_back(idle(1, 2, 2'b01, 1, 0, 1));
        vq.push_back(idle(1, 2, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        for (int k = 0; k < vq.size(); k++) step(vq[k]);

        // Same-tag completion on ports 0 and 2, plus a completion to an unallocated tag
        step(mk_rst());
        for (int i = 0; i < 5; i++) step(al(i, i));
        v    = al(5, 5);
        v.cv = 3'b010;
        v.t1 = 4'd6;
        v.d1 = 32'h6666_6666;
        step(v);
        step(mk(0, 3'b111, 0, 1, 2, 0, 0, 1, 6, 0, 0, 0, 0, 0, 6));
        step(mk(0, 3'b011, 3, 4, 0, 0, 0, 1, 6, 2'b11, 0, 1, 0, 0, 6));
        v    = mk(1, 3'b101, 5, 0, 5, 0, 0, 1, 6, 2'b11, 2, 3, 0, 0, 4);
        v.d0 = 32'h0000_00AA;
        v.d2 = 32'h0000_00BB;
        step(v);
        v      = idle(1, 7, 2'b11, 4, 5, 3);
        v.ecd1 = 32'h0000_00BB;
        step(v);
        step(idle(1, 7, 0, 0, 0, 1));

        // Reset mid-operation wins over concurrent alloc and completion
        v     = mk(1, 3'b001, 6, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1);
        v.rst = 1'b1;
        v.chk = 1'b0;
        step(v);
        step(idle(1, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_mc.md
# rob_mc

Parametrised reorder buffer with multi-port completion, multi-wide in-order commit and branch-mispredict flush. It sits between the instruction queue/dispatch stage and the architectural register file. It allocates one tag per dispatched instruction, absorbs results from several completion (CDB) ports, and retires up to COMMIT_W ready entries per cycle in program order. A mispredicted branch at commit flushes every younger entry.

## Interface
- DATA_W, 32, result data width
- DEPTH, 16, entry count; must be a power of two, at least 4
- TAG_W, $clog2(DEPTH), tag width
- CDB_PORTS, 3, number of completion ports
- COMMIT_W, 2, maximum retirements per cycle; must be at most DEPTH
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_pc  in  32  instruction PC
- alloc_rd  in  5  destination register (0 = none)
- alloc_ready  out  1  entry can be accepted this cycle
- alloc_tag  out  TAG_W  tag that will be given to the current request (tail pointer)
- cdb_valid  in  CDB_PORTS  per-port completion strobe
- cdb_tag  in  CDB_PORTS×TAG_W  completing entry tag
- cdb_data  in  CDB_PORTS×DATA_W  result
- cdb_mispredict  in  CDB_PORTS  completing branch was mispredicted
- cdb_target  in  CDB_PORTS×32  correct next PC for a mispredicted branch
- commit_valid  out  COMMIT_W  slot i retires this cycle
- commit_tag / commit_rd / commit_data / commit_pc  out  COMMIT_W × (TAG_W / 5 / DATA_W / 32)  retiring entry fields
- flush  out  1  mispredict flush occurs at this clock edge
- flush_pc  out  32  redirect target; valid when flush is 1
- count  out  TAG_W+1  occupied entries
- empty  out  1  count == 0

## Operation
- Each entry stores: valid, ready, mispredict, pc, rd, data, target.
- head, tail: TAG_W-bit pointers that wrap naturally. count is tracked explicitly, so full and empty never depend on pointer comparison.
- Allocation:
  - alloc_ready = (count < DEPTH) && !flush. It is computed from registered state only; an allocation is never granted against a same-cycle commit.
  - On alloc_valid && alloc_ready: entry[tail] gets valid=1, ready=0, mispredict=0, plus pc and rd; tail increments.
- Completion:
  - For each port p with cdb_valid[p] and entry[cdb_tag[p]].valid: set ready=1 and store data, mispredict and target.
  - A completion to an invalid entry is ignored.
  - Two ports naming the same tag in one cycle: the highest port index wins.
- Commit:
  - Slot i is valid when entries head..head+i are all valid and ready, and no entry in head..head+i-1 is mispredicted.
  - A mispredicted entry retires as the last slot of its group.
  - head advances by the number of slots retired.
- Flush:
  - flush = 1 when some valid commit slot carries mispredict; flush_pc is that entry's target.
  - At that edge every entry is invalidated and tail is set to the post-commit head. count becomes 0.
  - CDB writes in the same cycle are discarded.
- count_next = count + accepted allocation − retired slots; it is 0 on flush.

## Timing
- Reset values: head=tail=0, count=0, all entries valid=0/ready=0; alloc_ready=1, alloc_tag=0, commit_valid=0, flush=0, empty=1.
- Reset asserted mid-operation discards all entries at the next edge, regardless of other inputs.
- Allocate in cycle N. The earliest completion is in cycle N+1. The entry shows ready in N+2, so the earliest commit is cycle N+2.
- commit_*, flush and flush_pc are combinational from registered state; the state update happens at the same edge.
- alloc_tag is valid in every cycle; dispatch samples it only when alloc_ready is 1.
- Wrap-around: tag DEPTH−1 is followed by tag 0. A commit group may straddle the wrap.
- Full and committing in the same cycle: alloc_ready stays 0 that cycle.

## Test plan
- Reset, then 16 allocations with no completions -> tags 0..15, count=16, alloc_ready=0 on the 17th request, empty=0.
- Complete tags 1 then 0 via different ports -> no commit until tag 0 is ready; then commit_valid=2'b11 with tags 0 and 1 in the same cycle, count drops by 2.
- Complete tags 0 and 2 only -> commit tag 0 alone, tag 2 held until tag 1 completes.
- Tag 3 completes with cdb_mispredict=1, cdb_target=0x0000_0400, tags 4..7 allocated -> tag 3 retires with flush=1, flush_pc=0x400; next cycle count=0, empty=1, alloc_tag = 4 (post-commit head).
- Fill to 16, retire 2, allocate 2 -> alloc_tag wraps 15→0→1; commit order stays correct across the wrap.
- Ports 0 and 2 complete tag 5 in the same cycle with data 0xAA / 0xBB -> retired commit_data=0xBB. Completion to an unallocated tag -> no state change.
